snow64_long_mul_u16_by_u8_radix_16: RTL and testbench

Multi-cycle unsigned multiplier: u16 × u8 → u24, consuming 4 multiplicand bits per cycle from a precomputed table of multiples (b×0 … b×15). It is the inverse-direction companion of the radix-16 u16-by-u8 long divider. It uses the same start/valid/can_accept_cmd command protocol, so one control sequencer can drive both. Its main use is quotient×divisor products, e.g. for remainder reconstruction and checking.

---
 rtl/snow64_long_mul_u16_by_u8_radix_16_pkg.sv | 38 +++
 rtl/snow64_long_mul_u16_by_u8_radix_16.sv | 90 +++++++++
 tb/tb_snow64_long_mul_u16_by_u8_radix_16.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/snow64_long_mul_u16_by_u8_radix_16_pkg.sv
// Shared widths, port structs and state enum for the radix-16 u16 x u8 long multiplier.
// Optional addend input enabled by SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN.
package PkgSnow64LongMul;

  localparam int unsigned WidthInA          = 16;
  localparam int unsigned MsbPosInA         = WidthInA - 1;
  localparam int unsigned WidthInB          = 8;
  localparam int unsigned MsbPosInB         = WidthInB - 1;
  localparam int unsigned WidthInC          = 8;
  localparam int unsigned MsbPosInC         = WidthInC - 1;
  localparam int unsigned WidthOutData      = 24;
  localparam int unsigned MsbPosOutData     = WidthOutData - 1;
  localparam int unsigned WidthTableEntry   = 12;
  localparam int unsigned MsbPosTableEntry  = WidthTableEntry - 1;
  localparam int unsigned Radix             = 16;
  localparam int unsigned BitsPerIter       = 4;

  typedef enum logic {
    StIdle,
    StWorking
  } state_t;

  typedef struct packed {
    logic                 start;
    logic [MsbPosInA:0]   a;
    logic [MsbPosInB:0]   b;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    logic [MsbPosInC:0]   c;
`endif
  } PortIn_LongMulU16ByU8;

  typedef struct packed {
    logic [MsbPosOutData:0] data;
    logic                   valid;
    logic                   can_accept_cmd;
  } PortOut_LongMulU16ByU8;

endpackage

// File: rtl/snow64_long_mul_u16_by_u8_radix_16.sv
// Multi-cycle u16 x u8 -> u24 multiplier, one multiplicand nibble per cycle via a b*k table.
// Define SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN to add an 8-bit addend c to the result.
module snow64_long_mul_u16_by_u8_radix_16
  import PkgSnow64LongMul::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  PortIn_LongMulU16ByU8  in,
  output PortOut_LongMulU16ByU8 out
);

  state_t                      state;
  logic [MsbPosInA:0]          a_q;
  logic [MsbPosTableEntry:0]   table_q [Radix];
  logic [MsbPosOutData:0]      acc_q;
  logic [MsbPosOutData:0]      acc_next;
  logic [MsbPosOutData:0]      data_q;
  logic [1:0]                  idx_q;
  logic                        valid_q;
  logic                        can_q;
  logic [BitsPerIter-1:0]      nibble;
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
  logic [MsbPosInC:0]          c_q;
`endif

  always_comb begin
    nibble   = a_q[{idx_q, 2'b00} +: BitsPerIter];
    acc_next = {acc_q[MsbPosOutData-BitsPerIter:0], {BitsPerIter{1'b0}}}
             + {{(WidthOutData - WidthTableEntry){1'b0}}, table_q[nibble]};
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    // Addend folds in on the last nibble so the result is a*b + c.
    if (idx_q == 2'd0) begin
      acc_next = acc_next + {{(WidthOutData - WidthInC){1'b0}}, c_q};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      a_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      can_q   <= 1'b1;
      for (int unsigned k = 0; k < Radix; k++) begin
        table_q[k] <= '0;
      end
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
      c_q     <= '0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (in.start) begin
            state   <= StWorking;
            a_q     <= in.a;
            for (int unsigned k = 0; k < Radix; k++) begin
              table_q[k] <= {4'b0000, in.b} * k[3:0];
            end
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
            c_q     <= in.c;
`endif
            acc_q   <= '0;
            idx_q   <= 2'd3;
            valid_q <= 1'b0;
            can_q   <= 1'b0;
          end
        end
        StWorking: begin
          acc_q <= acc_next;
          idx_q <= idx_q - 2'd1;
          if (idx_q == 2'd0) begin
            data_q  <= acc_next;
            state   <= StIdle;
            valid_q <= 1'b1;
            can_q   <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign out.data           = data_q;
  assign out.valid          = valid_q;
  assign out.can_accept_cmd = can_q;

endmodule

// File: tb/tb_snow64_long_mul_u16_by_u8_radix_16.sv
// Self-checking bench: cycle-level transaction model plus literal result checks.
module tb_snow64_long_mul_u16_by_u8_radix_16;
  import PkgSnow64LongMul::*;

  logic                  clk = 1'b0;
  logic                  rst;
  PortIn_LongMulU16ByU8  din;
  PortOut_LongMulU16ByU8 dout;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model: a command occupies 4 cycles, then presents a*b(+c) until the next accept.
  int          m_rem   = 0;
  logic [23:0] m_pend  = '0;
  logic [23:0] m_data  = '0;
  logic        m_valid = 1'b0;

  snow64_long_mul_u16_by_u8_radix_16 dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] product(input PortIn_LongMulU16ByU8 p);
    logic [23:0] r;
    r = {8'h00, p.a} * {16'h0000, p.b};
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    r = r + {16'h0000, p.c};
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rem   <= 0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (m_rem == 0) begin
      if (din.start) begin
        m_rem   <= 4;
        m_pend  <= product(din);
        m_valid <= 1'b0;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_data  <= m_pend;
        m_valid <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (dout.valid !== m_valid || dout.can_accept_cmd !== (m_rem == 0) ||
          dout.data !== m_data) begin
        n_err++;
        $display("FAIL cycle t=%0t valid=%b want %b can=%b want %b data=%h want %h", $time,
                 dout.valid, m_valid, dout.can_accept_cmd, (m_rem == 0), dout.data, m_data);
      end
    end
  end

  task automatic check_lit(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dout.can_accept_cmd === 1'b1) break;
    end
    if (k == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL %s idle timeout got can=%b want 1", name, dout.can_accept_cmd);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dout.valid === 1'b1) break;
    end
    if (k == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL %s valid timeout got valid=%b want 1", name, dout.valid);
    end
  endtask

  task automatic set_c(input logic [7:0] c);
`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    din.c = c;
`else
    if (c != 8'h00) din.start = din.start;
`endif
  endtask

  task automatic run_cmd(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [23:0] exp, input string name);
    wait_idle(name);
    @(posedge clk); #1;
    din.a = a;
    din.b = b;
    set_c(c);
    din.start = 1'b1;
    @(posedge clk); #1;
    din.start = 1'b0;
    din.a = 16'hDEAD;
    din.b = 8'hBE;
    wait_valid(name);
    check_lit(name, dout.data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    din = '0;
    rst = 1'b1;
    @(posedge clk); #1 cmp_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_lit("rst_valid", {23'd0, dout.valid}, 24'd0);
    check_lit("rst_can", {23'd0, dout.can_accept_cmd}, 24'd1);
    check_lit("rst_data", dout.data, 24'h000000);

    run_cmd(16'h1234, 8'h56, 8'h00, 24'h061D78, "basic");
    repeat (3) @(negedge clk);
    check_lit("hold", dout.data, 24'h061D78);
    run_cmd(16'hFFFF, 8'hFF, 8'h00, 24'hFEFF01, "max");
    run_cmd(16'hFFFF, 8'h00, 8'h00, 24'h000000, "b_zero");
    run_cmd(16'h0000, 8'hFF, 8'h00, 24'h000000, "a_zero");

    // start held high with inputs changing every cycle
    wait_idle("held");
    @(posedge clk); #1 din.start = 1'b1;
    repeat (16) begin
      din.a = 16'($urandom);
      din.b = 8'($urandom);
      set_c(8'h00);
      @(posedge clk); #1;
    end
    din.start = 1'b0;

    // start pulses and input churn while working
    wait_idle("pulse");
    @(posedge clk); #1;
    din.a = 16'h00FF;
    din.b = 8'h02;
    set_c(8'h00);
    din.start = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      din.start = 1'($urandom);
      din.a = 16'($urandom);
      din.b = 8'($urandom);
      @(posedge clk); #1;
    end
    din.start = 1'b0;
    @(negedge clk);
    check_lit("pulse", dout.data, 24'h0001FE);

    // reset during the second working cycle
    wait_idle("midrst");
    @(posedge clk); #1;
    din.a = 16'h1234;
    din.b = 8'h56;
    din.start = 1'b1;
    @(posedge clk); #1 din.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    din.start = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    din.start = 1'b0;
    @(negedge clk);
    check_lit("midrst_data", dout.data, 24'h000000);
    check_lit("midrst_can", {23'd0, dout.can_accept_cmd}, 24'd1);
    repeat (6) @(negedge clk);
    check_lit("midrst_novalid", {23'd0, dout.valid}, 24'd0);
    run_cmd(16'h0003, 8'h05, 8'h00, 24'h00000F, "after_rst");

`ifdef SNOW64_LONG_MUL_U16_BY_U8_ADDEND_EN
    run_cmd(16'd142, 8'd7, 8'd6, 24'h0003E8, "addend");
    run_cmd(16'hFFFF, 8'hFF, 8'hFF, 24'hFF0000, "addend_max");
`endif

    // random traffic with occasional resets
    repeat (300) begin
      @(posedge clk); #1;
      din.start = ($urandom_range(0, 2) != 0);
      din.a = 16'($urandom);
      din.b = 8'($urandom);
      set_c(8'($urandom));
      rst = ($urandom_range(0, 24) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    din.start = 1'b0;
    wait_idle("drain");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
